// File: rtl/led_shift_out.sv
// rtl/led_shift_out.sv - serializes a parallel LED pattern to a 74HC595-style shift register with global PWM dimming
//
// Ports:
//   clock       system clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset
//   leds        parallel LED pattern, bit WIDTH-1 is the leftmost LED (shifted first)
//   brightness  global duty, 0 = off, all-ones = fully on
//   busy        high while a frame is being shifted or latched
//   sr_data     serial data (SER), stable while sr_clock is high
//   sr_clock    shift clock (SRCLK), external register samples on its rising edge
//   sr_latch    storage latch pulse (RCLK), active high, CLK_DIV cycles wide
//   sr_oe_n     active-low output enable, carries the brightness PWM

module led_shift_out #(
    parameter int WIDTH    = 8,
    parameter int CLK_DIV  = 4,
    parameter int PWM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [WIDTH-1:0]    leds,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                busy,
    output logic                sr_data,
    output logic                sr_clock,
    output logic                sr_latch,
    output logic                sr_oe_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    // Holds only the bits still to be sent; the MSB goes straight to sr_data at frame start.
    logic [WIDTH-2:0]    shift_reg;
    // Value actually shifted last, so a static pattern causes no bus traffic.
    logic [WIDTH-1:0]    shadow;
    // Forces one frame after reset so the external register reaches a known state.
    logic                refresh_pending;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic start;
    logic pwm_on;

    assign start  = refresh_pending || (leds != shadow);
    // All-ones brightness must be fully on, which counter < brightness alone cannot reach.
    assign pwm_on = (&brightness) || (pwm_cnt < brightness);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            div_cnt         <= '0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            shadow          <= '0;
            refresh_pending <= 1'b1;
            busy            <= 1'b0;
            sr_data         <= 1'b0;
            sr_clock        <= 1'b0;
            sr_latch        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (start) begin
                        shift_reg       <= leds[WIDTH-2:0];
                        shadow          <= leds;
                        refresh_pending <= 1'b0;
                        sr_data         <= leds[WIDTH-1];
                        sr_clock        <= 1'b0;
                        bit_cnt         <= BIT_LAST;
                        busy            <= 1'b1;
                        state           <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sr_clock) begin
                            sr_clock <= 1'b1;
                        end else begin
                            // Falling transition: data moves only here, never while SRCLK is high.
                            sr_clock <= 1'b0;
                            if (bit_cnt == '0) begin
                                sr_latch <= 1'b1;
                                state    <= LATCH;
                            end else begin
                                bit_cnt   <= bit_cnt - 1'b1;
                                sr_data   <= shift_reg[WIDTH-2];
                                shift_reg <= shift_reg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        sr_latch <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running dimming, independent of the frame state machine.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            sr_oe_n <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            sr_oe_n <= !pwm_on;
        end
    end

endmodule

// File: tb/tb_led_shift_out.sv
// tb/tb_led_shift_out.sv - directed self-checking bench for led_shift_out with a 74HC595 receiver model

module tb_led_shift_out;

    logic       clock;
    logic       reset_n;
    logic [7:0] a_leds;
    logic [3:0] a_bright;
    logic       a_busy, a_data, a_clk, a_lat, a_oe;
    logic [7:0] b_leds;
    logic [3:0] b_bright;
    logic       b_busy, b_data, b_clk, b_lat, b_oe;

    int checks;
    int failures;

    led_shift_out #(.WIDTH(8), .CLK_DIV(4), .PWM_BITS(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .leds(a_leds), .brightness(a_bright),
        .busy(a_busy), .sr_data(a_data), .sr_clock(a_clk), .sr_latch(a_lat), .sr_oe_n(a_oe)
    );

    led_shift_out #(.WIDTH(8), .CLK_DIV(1), .PWM_BITS(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .leds(b_leds), .brightness(b_bright),
        .busy(b_busy), .sr_data(b_data), .sr_clock(b_clk), .sr_latch(b_lat), .sr_oe_n(b_oe)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    // Receiver model and activity monitor for dut_a, sampled on the falling edge.
    logic [7:0] a_sr;
    logic [7:0] a_out;
    logic [7:0] a_log [0:63];
    int a_rises, a_latches, a_bits_frame, a_bits_at_latch;
    int a_ser_viol, a_lat_viol, a_lat_run, a_last_lat_w, a_busy_run, a_last_busy;
    logic a_prev_clk, a_prev_lat, a_prev_busy, a_prev_data;

    initial begin
        a_sr = 8'h00; a_out = 8'h00;
        a_rises = 0; a_latches = 0; a_bits_frame = 0; a_bits_at_latch = 0;
        a_ser_viol = 0; a_lat_viol = 0; a_lat_run = 0; a_last_lat_w = 0;
        a_busy_run = 0; a_last_busy = 0;
        a_prev_clk = 1'b0; a_prev_lat = 1'b0; a_prev_busy = 1'b0; a_prev_data = 1'b0;
    end

    always @(negedge clock) begin
        if (!reset_n) a_bits_frame = 0;
        if (a_clk && !a_prev_clk) begin
            a_sr = {a_sr[6:0], a_data};
            a_rises++;
            a_bits_frame++;
        end
        if (a_clk && a_prev_clk && (a_data !== a_prev_data)) a_ser_viol++;
        if (a_lat && !a_prev_lat) begin
            a_out = a_sr;
            a_log[a_latches % 64] = a_sr;
            a_latches++;
            a_bits_at_latch = a_bits_frame;
            a_bits_frame = 0;
            a_lat_run = 0;
            if (a_clk) a_lat_viol++;
        end
        if (a_lat) a_lat_run++;
        else if (a_prev_lat) a_last_lat_w = a_lat_run;
        if (a_busy) a_busy_run++;
        else if (a_prev_busy) begin
            a_last_busy = a_busy_run;
            a_busy_run = 0;
        end
        a_prev_clk = a_clk; a_prev_lat = a_lat; a_prev_busy = a_busy; a_prev_data = a_data;
    end

    // Receiver model for dut_b, plus a check that SRCLK toggles every cycle while shifting.
    logic [7:0] b_sr;
    logic [7:0] b_out;
    int b_bits_frame, b_bits_at_latch, b_alt_viol, b_busy_run, b_last_busy;
    logic b_prev_clk, b_prev_lat, b_prev_busy;

    initial begin
        b_sr = 8'h00; b_out = 8'h00;
        b_bits_frame = 0; b_bits_at_latch = 0; b_alt_viol = 0;
        b_busy_run = 0; b_last_busy = 0;
        b_prev_clk = 1'b0; b_prev_lat = 1'b0; b_prev_busy = 1'b0;
    end

    always @(negedge clock) begin
        if (!reset_n) b_bits_frame = 0;
        if (b_clk && !b_prev_clk) begin
            b_sr = {b_sr[6:0], b_data};
            b_bits_frame++;
        end
        if (b_busy && b_prev_busy && !b_lat && !b_prev_lat && (b_clk === b_prev_clk)) b_alt_viol++;
        if (b_lat && !b_prev_lat) begin
            b_out = b_sr;
            b_bits_at_latch = b_bits_frame;
            b_bits_frame = 0;
        end
        if (b_busy) b_busy_run++;
        else if (b_prev_busy) begin
            b_last_busy = b_busy_run;
            b_busy_run = 0;
        end
        b_prev_clk = b_clk; b_prev_lat = b_lat; b_prev_busy = b_busy;
    end

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({a_busy, a_data, a_clk, a_lat, a_oe} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_outputs: got busy,data,clk,lat,oe_n=%b required 00001",
                     {a_busy, a_data, a_clk, a_lat, a_oe});
        end
    endtask

    task automatic test_start_after_reset;
        int l0, r0;
        l0 = a_latches;
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (a_busy !== 1'b1) begin
            failures++;
            $display("FAIL start_within_1_cycle: busy=%b required 1", a_busy);
        end
        repeat (72) @(negedge clock);
        checks++;
        if (a_last_busy != 68) begin
            failures++;
            $display("FAIL reset_frame_busy_len: got %0d required 68", a_last_busy);
        end
        checks++;
        if (a_latches - l0 != 1 || a_out !== 8'h00 || a_bits_at_latch != 8) begin
            failures++;
            $display("FAIL reset_frame_content: latches=%0d out=%h bits=%0d required 1 00 8",
                     a_latches - l0, a_out, a_bits_at_latch);
        end
        checks++;
        if (a_last_lat_w != 4) begin
            failures++;
            $display("FAIL latch_width: got %0d required 4", a_last_lat_w);
        end
        l0 = a_latches;
        r0 = a_rises;
        repeat (1000) @(negedge clock);
        checks++;
        if (a_latches != l0 || a_rises != r0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL static_quiet: new latches=%0d new rises=%0d busy=%b required 0 0 0",
                     a_latches - l0, a_rises - r0, a_busy);
        end
    endtask

    task automatic test_pattern_a5;
        int sv0, lv0;
        sv0 = a_ser_viol;
        lv0 = a_lat_viol;
        a_leds = 8'hA5;
        repeat (75) @(negedge clock);
        checks++;
        if (a_out !== 8'hA5 || a_bits_at_latch != 8) begin
            failures++;
            $display("FAIL a5_received: got %h bits=%0d required a5 8", a_out, a_bits_at_latch);
        end
        checks++;
        if (a_ser_viol != sv0 || a_lat_viol != lv0) begin
            failures++;
            $display("FAIL a5_timing: ser_changes_high=%0d latch_with_clk_high=%0d required 0 0",
                     a_ser_viol - sv0, a_lat_viol - lv0);
        end
    endtask

    task automatic test_back_to_back;
        int l0;
        l0 = a_latches;
        a_leds = 8'h01;
        repeat (10) @(negedge clock);
        a_leds = 8'h80;
        repeat (20) @(negedge clock);
        a_leds = 8'hFF;
        repeat (200) @(negedge clock);
        checks++;
        if (a_latches - l0 != 2) begin
            failures++;
            $display("FAIL b2b_frame_count: got %0d required 2", a_latches - l0);
        end
        checks++;
        if (a_log[l0 % 64] !== 8'h01 || a_log[(l0 + 1) % 64] !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_values: got %h %h required 01 ff",
                     a_log[l0 % 64], a_log[(l0 + 1) % 64]);
        end
    endtask

    task automatic test_pwm;
        logic [3:0] levels [0:2];
        int         want [0:2];
        logic       samp [0:31];
        int         low, bad;
        levels[0] = 4'd0;  want[0] = 0;
        levels[1] = 4'd8;  want[1] = 16;
        levels[2] = 4'd15; want[2] = 32;
        for (int k = 0; k < 3; k++) begin
            a_bright = levels[k];
            repeat (3) @(negedge clock);
            low = 0;
            for (int i = 0; i < 32; i++) begin
                samp[i] = a_oe;
                if (!a_oe) low++;
                @(negedge clock);
            end
            checks++;
            if (low != want[k]) begin
                failures++;
                $display("FAIL pwm_low_count b=%0d: got %0d required %0d", levels[k], low, want[k]);
            end
            if (k == 1) begin
                bad = 0;
                for (int i = 0; i < 24; i++) if (samp[i] === samp[i + 8]) bad++;
                checks++;
                if (bad != 0) begin
                    failures++;
                    $display("FAIL pwm_8on_8off: %0d samples not inverted 8 cycles later, required 0", bad);
                end
            end
        end
        a_bright = 4'd4;
    endtask

    task automatic test_reset_mid_frame;
        a_leds = 8'h3C;
        @(negedge clock);
        repeat (19) @(negedge clock);
        checks++;
        if (a_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_busy: busy=%b required 1", a_busy);
        end
        #10 reset_n = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_data, a_clk, a_lat, a_oe} !== 5'b00001) begin
            failures++;
            $display("FAIL async_abort: got busy,data,clk,lat,oe_n=%b required 00001",
                     {a_busy, a_data, a_clk, a_lat, a_oe});
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (75) @(negedge clock);
        checks++;
        if (a_out !== 8'h3C || a_bits_at_latch != 8 || a_last_busy != 68) begin
            failures++;
            $display("FAIL resend_3c: got out=%h bits=%0d busy_len=%0d required 3c 8 68",
                     a_out, a_bits_at_latch, a_last_busy);
        end
    endtask

    task automatic test_clk_div1;
        int av0;
        av0 = b_alt_viol;
        b_leds = 8'h5A;
        repeat (30) @(negedge clock);
        checks++;
        if (b_out !== 8'h5A || b_bits_at_latch != 8) begin
            failures++;
            $display("FAIL div1_received: got %h bits=%0d required 5a 8", b_out, b_bits_at_latch);
        end
        checks++;
        if (b_last_busy != 17) begin
            failures++;
            $display("FAIL div1_busy_len: got %0d required 17", b_last_busy);
        end
        checks++;
        if (b_alt_viol != av0) begin
            failures++;
            $display("FAIL div1_srclk_alternate: %0d non-toggling cycles required 0", b_alt_viol - av0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        a_leds   = 8'h00;
        b_leds   = 8'h00;
        a_bright = 4'd15;
        b_bright = 4'd0;
        test_reset;
        a_bright = 4'd4;
        test_start_after_reset;
        test_pattern_a5;
        test_back_to_back;
        test_pwm;
        test_reset_mid_frame;
        test_clk_div1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
